// File: rtl/calc_sequencer.sv
// calc_sequencer: token-driven front end for the 4-bit calculator datapath.
// Collects operand A, an operator and operand B over a valid/ready key
// stream, holds them registered at the ALU inputs, captures the ALU
// result and offers it downstream; each delivered result becomes the
// next operand A so calculations can be chained.
module calc_sequencer #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [1:0]       key_type,
  input  logic [WIDTH-1:0] key_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  localparam logic [1:0] KEY_OPERAND  = 2'b00;
  localparam logic [1:0] KEY_OPERATOR = 2'b01;
  localparam logic [1:0] KEY_EQUALS   = 2'b10;
  localparam logic [1:0] KEY_CLEAR    = 2'b11;

  localparam logic [OPW-1:0] OP_NOT = OPW'(3'b100);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             err_q, err_d;
  logic             accept;

  // Handshake and status outputs are decoded directly from the registered state
  always_comb begin
    key_ready = (state_q == S_A) || (state_q == S_OP) || (state_q == S_B);
    busy      = (state_q == S_EXEC) || (state_q == S_OUT);
    res_valid = (state_q == S_OUT);
    accept    = key_valid && key_ready;
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_op    = alu_op_q;
    res_data  = res_data_q;
    err       = err_q;
  end

  // Next-state logic: token decode, illegal-token flagging, result capture and chaining
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    err_d      = err_q;

    if (accept && (key_type == KEY_CLEAR)) begin
      state_d  = S_A;
      alu_a_d  = '0;
      alu_b_d  = '0;
      alu_op_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (accept) begin
            if (key_type == KEY_OPERAND) begin
              alu_a_d = key_data;
              state_d = S_OP;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_OP: begin
          if (accept) begin
            if (key_type == KEY_OPERATOR) begin
              alu_op_d = key_data[OPW-1:0];
              if (key_data[OPW-1:0] == OP_NOT) begin
                alu_b_d = '0;
                state_d = S_EXEC;
              end else begin
                state_d = S_B;
              end
            end else if (key_type == KEY_EQUALS) begin
              res_data_d = alu_a_q;
              state_d    = S_OUT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_B: begin
          if (accept) begin
            if (key_type == KEY_OPERAND) begin
              alu_b_d = key_data;
              state_d = S_EXEC;
            end else if (key_type == KEY_OPERATOR) begin
              alu_op_d = key_data[OPW-1:0];
              if (key_data[OPW-1:0] == OP_NOT) begin
                alu_b_d = '0;
                state_d = S_EXEC;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_EXEC: begin
          res_data_d = alu_result;
          state_d    = S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            alu_a_d = res_data_q;
            state_d = S_OP;
          end
        end
        default: begin
          state_d = S_A;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

endmodule
